// File: rtl/logic_slice_seq.sv
// Multi-cycle bitwise logic unit: evaluates AND/OR/XOR/NOR over DATA_WIDTH bits
// by stepping one shared SLICE_WIDTH-bit slice per clock, least-significant first.
module logic_slice_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int SLICE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_zero,
    output logic                  busy
);

    localparam int NSLICES = DATA_WIDTH / SLICE_WIDTH;
    localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [DATA_WIDTH-1:0]   a_reg;
    logic [DATA_WIDTH-1:0]   b_reg;
    logic [1:0]              op_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [DATA_WIDTH-1:0]   result_reg;
    logic                    req_ready_reg;
    logic                    resp_valid_reg;
    logic                    resp_zero_reg;
    logic                    busy_reg;

    logic [SLICE_WIDTH-1:0]  a_slices [NSLICES];
    logic [SLICE_WIDTH-1:0]  b_slices [NSLICES];
    logic [SLICE_WIDTH-1:0]  slice_a;
    logic [SLICE_WIDTH-1:0]  slice_b;
    logic [SLICE_WIDTH-1:0]  slice_out;
    logic [DATA_WIDTH-1:0]   result_next;

    // Split the captured operands into slice lanes so the shared slice can pick one by index.
    generate
        for (genvar gi = 0; gi < NSLICES; gi++) begin : g_split
            assign a_slices[gi] = a_reg[gi*SLICE_WIDTH +: SLICE_WIDTH];
            assign b_slices[gi] = b_reg[gi*SLICE_WIDTH +: SLICE_WIDTH];
        end
    endgenerate

    assign slice_a = a_slices[idx_reg];
    assign slice_b = b_slices[idx_reg];

    // The single shared gate slice.
    always_comb begin
        slice_out = '0;
        case (op_reg)
            OP_AND:  slice_out = slice_a & slice_b;
            OP_OR:   slice_out = slice_a | slice_b;
            OP_XOR:  slice_out = slice_a ^ slice_b;
            OP_NOR:  slice_out = ~(slice_a | slice_b);
            default: slice_out = '0;
        endcase
    end

    // Result with the current slice merged in; lanes not selected keep their stored value.
    generate
        for (genvar gi = 0; gi < NSLICES; gi++) begin : g_merge
            assign result_next[gi*SLICE_WIDTH +: SLICE_WIDTH] =
                (idx_reg == IDX_W'(gi)) ? slice_out
                                        : result_reg[gi*SLICE_WIDTH +: SLICE_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            op_reg         <= OP_AND;
            idx_reg        <= '0;
            result_reg     <= '0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_zero_reg  <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (req_valid && !flush) begin
                        a_reg         <= req_a;
                        b_reg         <= req_b;
                        op_reg        <= req_op;
                        idx_reg       <= '0;
                        result_reg    <= '0;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        idx_reg       <= '0;
                        result_reg    <= '0;
                        req_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end else begin
                        result_reg <= result_next;
                        idx_reg    <= idx_reg + IDX_W'(1);
                        if (idx_reg == LAST_IDX) begin
                            resp_valid_reg <= 1'b1;
                            resp_zero_reg  <= (result_next == '0);
                            state_reg      <= DONE;
                        end
                    end
                end
                DONE: begin
                    // A flush here either discards the result or races a handshake
                    // that has already delivered it; both end in IDLE.
                    if (flush || resp_ready) begin
                        if (flush) begin
                            result_reg <= '0;
                        end
                        idx_reg        <= '0;
                        resp_valid_reg <= 1'b0;
                        resp_zero_reg  <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        busy_reg       <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    idx_reg        <= '0;
                    resp_valid_reg <= 1'b0;
                    resp_zero_reg  <= 1'b0;
                    req_ready_reg  <= 1'b1;
                    busy_reg       <= 1'b0;
                    state_reg      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_data  = result_reg;
    assign resp_zero  = resp_zero_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_logic_slice_seq.sv
// Scoreboard bench for logic_slice_seq: directed vectors plus a randomized stream,
// expected results queued at acceptance and checked by a forked response monitor.
module tb_logic_slice_seq;

    localparam int DW = 32;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [DW-1:0] req_a = '0;
    logic [DW-1:0] req_b = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_data;
    logic          resp_zero;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int accept_cycle = 0;
    int pushed = 0;
    int popped = 0;
    bit rand_stall = 1'b0;
    logic [DW:0] exp_q[$];

    logic_slice_seq #(.DATA_WIDTH(DW), .SLICE_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_zero(resp_zero), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] ref_op(input logic [1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_stall) resp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input bit expect_resp);
        int n;
        logic [DW-1:0] r;
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("accept_timeout", 64'(req_ready), 64'd1);
        tick();
        accept_cycle = cycle;
        req_valid = 1'b0;
        // Scramble inputs after the accept: captured operands must not follow them.
        req_a = $urandom;
        req_b = $urandom;
        req_op = 2'($urandom_range(0, 3));
        if (expect_resp) begin
            r = ref_op(op, a, b);
            exp_q.push_back({(r == '0), r});
            pushed++;
            $display("REQ  op=%0d a=%08h b=%08h exp=%08h", op, a, b, r);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(req_ready && exp_q.size() == 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("idle_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_data"}, 64'(resp_data), 64'd0);
        check({tag, "_resp_zero"}, 64'(resp_zero), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int seen;
        logic [1:0] op;

        fork
            forever begin
                logic [DW:0] e;
                @(negedge clk);
                if (!rst && resp_valid && resp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 64'(resp_data), 64'hDEAD_0000);
                    end else begin
                        e = exp_q.pop_front();
                        popped++;
                        $display("RESP data=%08h zero=%0d exp=%08h/%0d",
                                 resp_data, resp_zero, e[DW-1:0], e[DW]);
                        check("resp_data", 64'(resp_data), 64'(e[DW-1:0]));
                        check("resp_zero", 64'(resp_zero), 64'(e[DW]));
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // OR with latency measurement
        resp_ready = 1'b1;
        issue(2'b01, 32'h12345678, 32'h0F0F0F0F, 1'b1);
        for (int k = 1; k <= NS; k++) begin
            tick();
            check($sformatf("or_latency_valid_%0d", k), 64'(resp_valid), 64'(k == NS));
            check($sformatf("or_busy_%0d", k), 64'(busy), 64'd1);
            check($sformatf("or_req_ready_%0d", k), 64'(req_ready), 64'd0);
        end
        tick();
        check("or_after_hs_req_ready", 64'(req_ready), 64'd1);
        check("or_after_hs_valid", 64'(resp_valid), 64'd0);
        check("or_after_hs_busy", 64'(busy), 64'd0);

        // AND then NOR back-to-back
        issue(2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1);
        seen = accept_cycle;
        issue(2'b11, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        check("b2b_spacing", 64'(accept_cycle - seen), 64'(NS + 2));
        wait_idle();

        // Backpressure on XOR of equal operands
        resp_ready = 1'b0;
        issue(2'b10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        repeat (NS) tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_valid_%0d", i), 64'(resp_valid), 64'd1);
            check($sformatf("bp_data_%0d", i), 64'(resp_data), 64'd0);
            check($sformatf("bp_zero_%0d", i), 64'(resp_zero), 64'd1);
            check($sformatf("bp_busy_%0d", i), 64'(busy), 64'd1);
            check($sformatf("bp_req_ready_%0d", i), 64'(req_ready), 64'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(resp_valid), 64'd0);
        check("bp_release_req_ready", 64'(req_ready), 64'd1);

        // Flush on the second RUN cycle
        issue(2'b01, 32'hAAAA0000, 32'h0000AAAA, 1'b0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_req_ready", 64'(req_ready), 64'd1);
        check("flush_busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid) seen++;
            tick();
        end
        check("flush_no_resp", 64'(seen), 64'd0);

        // flush together with req_valid in IDLE must not accept
        req_valid = 1'b1;
        req_op = 2'b00;
        req_a = 32'h0000FFFF;
        req_b = 32'h00FF00FF;
        flush = 1'b1;
        tick();
        check("idle_flush_busy", 64'(busy), 64'd0);
        check("idle_flush_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b0;
        flush = 1'b0;
        issue(2'b10, 32'h0000FFFF, 32'h00FF00FF, 1'b1);
        wait_idle();

        // Reset in RUN
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_run");
        rst = 1'b0;

        // Reset in DONE with an unconsumed result
        resp_ready = 1'b0;
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        repeat (NS) tick();
        check("rst_done_pre_valid", 64'(resp_valid), 64'd1);
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_done");
        rst = 1'b0;
        resp_ready = 1'b1;
        tick();
        tick();
        check("rst_done_no_stale", 64'(resp_valid), 64'd0);

        // Random stream with consumer stalls
        rand_stall = 1'b1;
        for (int i = 0; i < 500; i++) begin
            op = 2'($urandom_range(0, 3));
            issue(op, $urandom, $urandom, 1'b1);
        end
        rand_stall = 1'b0;
        resp_ready = 1'b1;
        wait_idle();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_resp_count", 64'(popped), 64'(pushed));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
